// File: rtl/x_metric_argmax_pkg.sv
// Shared types for the X-metric argmax stage: FSM state encoding and metric width.
package x_metric_pkg;

  localparam int ACC_WIDTH_DEF = 32;
  localparam int NUM_CAND_DEF  = 16;

  function automatic int metric_w(input int acc_width);
    return 2 * acc_width;
  endfunction

  localparam int METRIC_W = metric_w(ACC_WIDTH_DEF);

  typedef logic [METRIC_W-1:0] metric_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/x_metric_argmax_if.sv
// Search-control and result bus between the trace stage and the argmax stage.
interface x_metric_argmax_if #(
  parameter int ACC_WIDTH = 32,
  parameter int NUM_CAND  = 16
);
  localparam int IDX_W    = $clog2(NUM_CAND);
  localparam int METRIC_W = 2 * ACC_WIDTH;

  logic                        start;
  logic                        trace_valid;
  logic signed [ACC_WIDTH-1:0] trace_r;
  logic signed [ACC_WIDTH-1:0] trace_i;
  logic [IDX_W-1:0]            cand_idx;
  logic                        busy;
  logic                        done;
  logic [IDX_W-1:0]            best_idx;
  logic [METRIC_W-1:0]         best_metric;
  logic [IDX_W-1:0]            second_idx;
  logic [METRIC_W-1:0]         second_metric;

  modport master (
    output start, trace_valid, trace_r, trace_i,
    input  cand_idx, busy, done, best_idx, best_metric, second_idx, second_metric
  );

  modport slave (
    input  start, trace_valid, trace_r, trace_i,
    output cand_idx, busy, done, best_idx, best_metric, second_idx, second_metric
  );
endinterface

// File: rtl/x_metric_argmax_cmag_sq.sv
// Two-stage |z|^2 pipeline: squares registered first, then their sum.
module cmag_sq #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear_i,
  input  logic                          in_valid_i,
  input  logic signed [ACC_WIDTH-1:0]   trace_r_i,
  input  logic signed [ACC_WIDTH-1:0]   trace_i_i,
  output logic                          out_valid_o,
  output logic [2*ACC_WIDTH-1:0]        metric_o
);
  localparam int MW   = 2 * ACC_WIDTH;
  localparam int SQ_W = MW - 1;

  logic signed [MW-1:0] r_ext, i_ext;
  logic [SQ_W-1:0]      sq_r_q, sq_i_q;
  logic [MW-1:0]        metric_q;
  logic                 s1_valid_q, s2_valid_q;

  // A square is never negative and peaks at 2^(2*ACC_WIDTH-2), so SQ_W bits hold it exactly.
  assign r_ext = MW'(trace_r_i);
  assign i_ext = MW'(trace_i_i);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sq_r_q     <= '0;
      sq_i_q     <= '0;
      metric_q   <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= in_valid_i & ~clear_i;
      s2_valid_q <= s1_valid_q & ~clear_i;
      if (in_valid_i) begin
        sq_r_q <= SQ_W'(r_ext * r_ext);
        sq_i_q <= SQ_W'(i_ext * i_ext);
      end
      if (s1_valid_q) begin
        metric_q <= MW'(sq_r_q) + MW'(sq_i_q);
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign metric_o    = metric_q;
endmodule

// File: rtl/x_metric_argmax.sv
// X-metric argmax: FSM, candidate counters and best/runner-up tracking over NUM_CAND traces.
// Optional runner-up tracking is built when XMETRIC_SECOND_BEST_EN is defined.
module x_metric_argmax
  import x_metric_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int NUM_CAND  = NUM_CAND_DEF
) (
  input  logic            clk,
  input  logic            rst,
  x_metric_argmax_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_CAND);
  localparam int MW    = metric_w(ACC_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [MW-1:0]    best_metric_q, best_metric_d;
  logic             first_q, first_d;
  logic             drain_q, drain_d;
  logic             accept, start_go, m_valid;
  logic [MW-1:0]    metric;
`ifdef XMETRIC_SECOND_BEST_EN
  logic [IDX_W-1:0] second_idx_q, second_idx_d;
  logic [MW-1:0]    second_metric_q, second_metric_d;
  logic             second_vld_q, second_vld_d;
`endif

  assign accept   = (state_q == COLLECT) && bus.trace_valid;
  assign start_go = bus.start && ((state_q == IDLE) || (state_q == DONE));

  cmag_sq #(.ACC_WIDTH(ACC_WIDTH)) u_cmag (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (start_go),
    .in_valid_i  (accept),
    .trace_r_i   (bus.trace_r),
    .trace_i_i   (bus.trace_i),
    .out_valid_o (m_valid),
    .metric_o    (metric)
  );

  // NOTE: every variable gets its hold value first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    cand_idx_d    = cand_idx_q;
    upd_idx_d     = upd_idx_q;
    best_idx_d    = best_idx_q;
    best_metric_d = best_metric_q;
    first_d       = first_q;
    drain_d       = drain_q;
`ifdef XMETRIC_SECOND_BEST_EN
    second_idx_d    = second_idx_q;
    second_metric_d = second_metric_q;
    second_vld_d    = second_vld_q;
`endif

    // Metrics leave the pipeline in acceptance order, so a local counter recovers their index.
    if (m_valid) begin
      upd_idx_d = upd_idx_q + 1'b1;
      if (first_q) begin
        first_d       = 1'b0;
        best_idx_d    = upd_idx_q;
        best_metric_d = metric;
      end else if (metric > best_metric_q) begin
`ifdef XMETRIC_SECOND_BEST_EN
        second_idx_d    = best_idx_q;
        second_metric_d = best_metric_q;
        second_vld_d    = 1'b1;
`endif
        best_idx_d    = upd_idx_q;
        best_metric_d = metric;
      end
`ifdef XMETRIC_SECOND_BEST_EN
      else if (!second_vld_q || (metric > second_metric_q)) begin
        second_idx_d    = upd_idx_q;
        second_metric_d = metric;
        second_vld_d    = 1'b1;
      end
`endif
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start_go) begin
          state_d       = COLLECT;
          cand_idx_d    = '0;
          upd_idx_d     = '0;
          best_idx_d    = '0;
          best_metric_d = '0;
          first_d       = 1'b1;
`ifdef XMETRIC_SECOND_BEST_EN
          second_idx_d    = '0;
          second_metric_d = '0;
          second_vld_d    = 1'b0;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (cand_idx_q == LAST_IDX) begin
            cand_idx_d = '0;
            drain_d    = 1'b0;
            state_d    = DRAIN;
          end else begin
            cand_idx_d = cand_idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cand_idx_q    <= '0;
      upd_idx_q     <= '0;
      best_idx_q    <= '0;
      best_metric_q <= '0;
      first_q       <= 1'b0;
      drain_q       <= 1'b0;
`ifdef XMETRIC_SECOND_BEST_EN
      second_idx_q    <= '0;
      second_metric_q <= '0;
      second_vld_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cand_idx_q    <= cand_idx_d;
      upd_idx_q     <= upd_idx_d;
      best_idx_q    <= best_idx_d;
      best_metric_q <= best_metric_d;
      first_q       <= first_d;
      drain_q       <= drain_d;
`ifdef XMETRIC_SECOND_BEST_EN
      second_idx_q    <= second_idx_d;
      second_metric_q <= second_metric_d;
      second_vld_q    <= second_vld_d;
`endif
    end
  end

  assign bus.cand_idx    = cand_idx_q;
  assign bus.busy        = (state_q == COLLECT) || (state_q == DRAIN);
  assign bus.done        = (state_q == DONE);
  assign bus.best_idx    = best_idx_q;
  assign bus.best_metric = best_metric_q;
`ifdef XMETRIC_SECOND_BEST_EN
  assign bus.second_idx    = second_idx_q;
  assign bus.second_metric = second_metric_q;
`else
  assign bus.second_idx    = '0;
  assign bus.second_metric = '0;
`endif
endmodule

// File: tb/tb_x_metric_argmax.sv
// Directed bench for x_metric_argmax with NUM_CAND=4, ACC_WIDTH=32.
module tb_x_metric_argmax;
  import x_metric_pkg::*;

`ifdef XMETRIC_SECOND_BEST_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  x_metric_argmax_if #(.ACC_WIDTH(32), .NUM_CAND(4)) bus ();

  x_metric_argmax #(.ACC_WIDTH(32), .NUM_CAND(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drive(input logic signed [31:0] r, input logic signed [31:0] i);
    bus.trace_valid = 1'b1;
    bus.trace_r     = r;
    bus.trace_i     = i;
    @(negedge clk);
    bus.trace_valid = 1'b0;
    bus.trace_r     = '0;
    bus.trace_i     = '0;
  endtask

  // Called at the first negedge after the last valid; done must appear 3 cycles after that valid.
  task automatic wait_done(input string tag);
    int lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'd3);
  endtask

  task automatic check_results(input string tag, input logic [1:0] bi, input metric_t bm,
                               input logic [1:0] si, input metric_t sm);
    check({tag, "_best_idx"}, 64'(bus.best_idx), 64'(bi));
    check({tag, "_best_metric"}, bus.best_metric, bm);
    check({tag, "_second_idx"}, 64'(bus.second_idx), SB_EN ? 64'(si) : 64'd0);
    check({tag, "_second_metric"}, bus.second_metric, SB_EN ? sm : 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cand_idx"}, 64'(bus.cand_idx), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check_results(tag, 2'd0, 64'd0, 2'd0, 64'd0);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.trace_valid = 1'b0;
    bus.trace_r     = '0;
    bus.trace_i     = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("reset");

    // Basic search: metrics 25,25,2,4; tie on best keeps index 0.
    do_start();
    check("a_busy", 64'(bus.busy), 64'd1);
    check("a_cand0", 64'(bus.cand_idx), 64'd0);
    drive(32'sd3, 32'sd4);
    check("a_cand1", 64'(bus.cand_idx), 64'd1);
    drive(-32'sd5, 32'sd0);
    check("a_cand2", 64'(bus.cand_idx), 64'd2);
    drive(32'sd1, 32'sd1);
    check("a_cand3", 64'(bus.cand_idx), 64'd3);
    drive(32'sd0, -32'sd2);
    check("a_cand_wrap", 64'(bus.cand_idx), 64'd0);
    check("a_busy_drain", 64'(bus.busy), 64'd1);
    check("a_done_early", 64'(bus.done), 64'd0);
    wait_done("a");
    check("a_busy_in_done", 64'(bus.busy), 64'd0);
    check_results("a", 2'd0, 64'd25, 2'd1, 64'd25);
    @(negedge clk);
    check("a_done_pulse", 64'(bus.done), 64'd0);
    check("a_hold_metric", bus.best_metric, 64'd25);

    // Reset held 2 cycles while idle.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_zero("idle_rst");

    // Extreme input: (-2^31)^2 * 2 = 2^63 must not wrap.
    do_start();
    drive(32'sd0, 32'sd0);
    drive(32'sh8000_0000, 32'sh8000_0000);
    drive(32'sd0, 32'sd0);
    drive(32'sd0, 32'sd0);
    wait_done("ext");
    check_results("ext", 2'd1, 64'h8000_0000_0000_0000, 2'd0, 64'd0);

    // Protocol: trace_valid in IDLE ignored.
    repeat (2) @(negedge clk);
    drive(32'sd7, 32'sd7);
    repeat (3) @(negedge clk);
    check("p_idle_cand", 64'(bus.cand_idx), 64'd0);
    check("p_idle_busy", 64'(bus.busy), 64'd0);
    check("p_idle_best", bus.best_metric, 64'h8000_0000_0000_0000);

    // Protocol: start during COLLECT ignored; metrics 1,4,4,2.
    do_start();
    drive(32'sd1, 32'sd0);
    do_start();
    check("p_start_cand", 64'(bus.cand_idx), 64'd1);
    check("p_start_busy", 64'(bus.busy), 64'd1);
    drive(32'sd0, 32'sd2);
    check("p_cand2", 64'(bus.cand_idx), 64'd2);
    drive(32'sd2, 32'sd0);
    drive(32'sd1, 32'sd1);
    check("p_cand_wrap", 64'(bus.cand_idx), 64'd0);
    wait_done("p");
    check_results("p", 2'd1, 64'd4, 2'd2, 64'd4);

    // Reset mid-COLLECT discards in-flight data.
    repeat (2) @(negedge clk);
    do_start();
    drive(32'sd100, 32'sd0);
    drive(32'sd0, 32'sd100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_zero("collect_rst");
    do_start();
    drive(32'sd1, 32'sd2);
    drive(32'sd2, 32'sd1);
    drive(32'sd0, 32'sd3);
    drive(-32'sd3, 32'sd0);
    wait_done("r");
    check_results("r", 2'd2, 64'd9, 2'd3, 64'd9);

    // Same traces as the basic search, with 5-cycle gaps.
    repeat (2) @(negedge clk);
    do_start();
    drive(32'sd3, 32'sd4);
    repeat (5) @(negedge clk);
    drive(-32'sd5, 32'sd0);
    repeat (5) @(negedge clk);
    drive(32'sd1, 32'sd1);
    repeat (5) @(negedge clk);
    check("g_busy_gap", 64'(bus.busy), 64'd1);
    drive(32'sd0, -32'sd2);
    wait_done("g");
    check_results("g", 2'd0, 64'd25, 2'd1, 64'd25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
